// File: rtl/switch_pkg.sv
// Shared switch definitions: port count, address width, entry layout and
// the ingress receive FSM state encoding.
package switch_pkg;

    localparam int NPORTS     = 4;
    localparam int ADRW       = 2;
    localparam int DW_DEFAULT = 4;

    typedef struct packed {
        logic [ADRW-1:0]       adr;
        logic [DW_DEFAULT-1:0] dat;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_LOW
    } rx_state_t;

endpackage

// File: rtl/ingress_fifo.sv
// Synchronous FIFO with combinational head read and registered full/empty
// flags derived from an explicit occupancy counter.
module ingress_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   occ_reg;
    logic [AW:0]   occ_next;
    logic          full_reg;
    logic          empty_reg;
    logic          do_push;
    logic          do_pop;

    // Flags are the registered view, so a pop from full never frees a slot
    // for a push in the same cycle.
    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg;

    always_comb begin
        occ_next = occ_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            occ_reg   <= occ_next;
            full_reg  <= (occ_next == (AW+1)'(DEPTH));
            empty_reg <= (occ_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wdata;
    end

    assign rdata = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/switch_ingress.sv
// Switch ingress port: valid/ack receive FSM into a FIFO whose head raises a
// one-hot crossbar request until granted.
module switch_ingress
    import switch_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic              clk_i2,
    input  logic              rst_i,
    input  logic              validtx,
    input  logic [ADRW-1:0]   adr_i,
    input  logic [DW-1:0]     dat_i,
    output logic              acktx,
    output logic [NPORTS-1:0] req_o,
    output logic [DW-1:0]     dat_o,
    input  logic [NPORTS-1:0] gnt_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [7:0]        cnt_o
);

    localparam int EW = ADRW + DW;

    rx_state_t       state_reg;
    rx_state_t       state_next;
    logic            acktx_reg;
    logic            acktx_next;
    logic [7:0]      cnt_reg;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;
    logic [ADRW-1:0] head_adr;
    logic [DW-1:0]   head_dat;
    logic            full;
    logic            empty;

    // WAIT_LOW holds off until the device releases the word it is still
    // presenting, so one word is never accepted twice.
    always_comb begin
        state_next = state_reg;
        acktx_next = 1'b0;
        push       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (validtx && !full) begin
                    push       = 1'b1;
                    acktx_next = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:      state_next = WAIT_LOW;
            WAIT_LOW: if (!validtx) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i2) begin
        if (rst_i) begin
            state_reg <= IDLE;
            acktx_reg <= 1'b0;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            acktx_reg <= acktx_next;
            if (push) cnt_reg <= cnt_reg + 8'd1;
        end
    end

    ingress_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i2),
        .srst  (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata ({adr_i, dat_i}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign head_adr = head[EW-1 -: ADRW];
    assign head_dat = head[DW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_req
            assign req_o[gi] = !empty && (head_adr == ADRW'(gi));
        end
    endgenerate

    assign pop     = |(gnt_i & req_o);
    assign dat_o   = empty ? '0 : head_dat;
    assign acktx   = acktx_reg;
    assign full_o  = full;
    assign empty_o = empty;
    assign cnt_o   = cnt_reg;

endmodule

// File: doc/switch_ingress.md
# switch_ingress

Ingress port of the 4-port switch. It sits directly downstream of a traffic-generator device and consumes that device's `validtx`/`adr_i`/`dat_i` stream, answering with a single-cycle `acktx` pulse. Accepted words go into a small FIFO. The FIFO head is presented to the crossbar as a one-hot request toward the addressed output port, and stays there until granted.

## Interface
- `DW`, default 4: data width.
- `DEPTH`, default 4: FIFO entries; must be a power of 2, minimum 2.
- `clk_i2`  in  1: sole clock; all state updates on its rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `validtx`  in  1: device has a word on `adr_i`/`dat_i`; held high until acked.
- `adr_i`  in  2: destination output port, 0..3.
- `dat_i`  in  DW: payload.
- `acktx`  out  1: registered accept pulse to device, exactly one cycle per accepted word.
- `req_o`  out  4: one-hot request to crossbar, equal to `1 << head.adr` when FIFO is non-empty, else 0.
- `dat_o`  out  DW: head payload; 0 when FIFO is empty.
- `gnt_i`  in  4: crossbar grant; a pop occurs when `|(gnt_i & req_o)`.
- `full_o`  out  1: FIFO holds DEPTH entries.
- `empty_o`  out  1: FIFO holds 0 entries.
- `cnt_o`  out  8: total words accepted since reset; wraps 255 -> 0.

## Operation
- Reset values: `acktx`=0, `req_o`=0, `dat_o`=0, `cnt_o`=0, `empty_o`=1, `full_o`=0, FSM in IDLE, FIFO pointers 0.
- The receive FSM has 3 states.
  - IDLE: if `validtx` && !`full_o`, push {`adr_i`,`dat_i`}, increment `cnt_o`, set `acktx`<=1, and go to ACK. Otherwise stay in IDLE with `acktx`=0.
  - ACK: set `acktx`<=0 and go to WAIT_LOW. `acktx` is therefore high for exactly one cycle.
  - WAIT_LOW: `validtx` is ignored. Go to IDLE on the first cycle `validtx`=0. This prevents double-accepting the word the device is still holding.
- A full FIFO means no ack. `validtx` may stay high indefinitely, and the word is accepted on the first IDLE cycle with `full_o`=0.
- Transmit side: head entry drives `req_o`/`dat_o` combinationally from the FIFO read port.
  - Pop on `|(gnt_i & req_o)`.
  - Grant bits that do not match `req_o` are ignored.
  - `gnt_i` is ignored while empty.
- Push and pop in the same cycle: occupancy is unchanged and order is preserved.
- Push eligibility uses `full_o` as registered at the start of the cycle. A pop from a full FIFO does not enable a push in the same cycle.
- Arithmetic widths:
  - FIFO pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy is log2(DEPTH)+1 bits.
  - `cnt_o` is an 8-bit modulo counter.
- Reset mid-operation: all entries are dropped, the FSM returns to IDLE, and a pending `acktx` pulse is cleared the next cycle. The upstream device shares `rst_i`.

## Timing
- If `validtx` is high in IDLE in cycle c and the FIFO is not full:
  - `acktx` is high in cycle c+1.
  - `cnt_o` updates in c+1.
  - The word appears on `req_o`/`dat_o` in c+1 if the FIFO was empty.
- If `gnt_i` matches in cycle g, the next entry (or `req_o`=0) appears in g+1. Minimum fall-through is one cycle.
- The device drops `validtx` in c+2. WAIT_LOW sees this and returns to IDLE at c+3.
- The earliest next accept is c+3. The device's own recovery is longer, so no handshake cycle is lost.
- `full_o`/`empty_o` are registered and reflect occupancy after the previous edge.

## Structure
- Shared package `switch_pkg` holds:
  - `NPORTS`=4 and `ADRW`=2.
  - Entry typedef {adr, dat}.
  - Receive FSM state enum {IDLE, ACK, WAIT_LOW}.
- Sub-module `ingress_fifo`: synchronous DEPTH x (ADRW+DW) FIFO with push/pop, full/empty, and combinational head read. `switch_ingress` contains the FSM, one-hot decode, grant match and counter.

## Test plan
- Reset: assert `rst_i` 3 cycles with `validtx`=1. Required: `acktx`=0, `req_o`=0, `dat_o`=0, `cnt_o`=0, `empty_o`=1 throughout and on the first cycle after release.
- Single word: adr=2, dat=9, `gnt_i`=4'hF. Required: `acktx` high exactly 1 cycle; `req_o`=4'b0100 with `dat_o`=9 for 1 cycle; `cnt_o`=1; no second ack while `validtx` is still high.
- Paired with a device instance (init=0), `gnt_i`=4'hF. Required: the (adr,dat) sequence (0,1),(0,5),(2,9),(3,D) appears on `req_o`/`dat_o` in that order, then traffic stops with `cnt_o`=4.
- Backpressure: `gnt_i`=0 and 4 words pushed. Required: `full_o`=1, and the 5th `validtx` gets no ack. Then pulse `gnt_i`=`req_o` for 1 cycle: the head pops, `full_o` drops, and the 5th word is acked the following cycle.
- Simultaneous push and pop at occupancy 2. Required: occupancy stays 2 and the output order is FIFO.
- Reset while the FSM is in ACK with 2 entries stored. Required: `acktx`=0, `req_o`=0, `empty_o`=1, `cnt_o`=0 on the first cycle after the reset edge.
